seq_shifter: RTL and testbench
==============================

# seq_shifter

Parametrised, multi-cycle iterative shifter/rotator with a start/done handshake. It succeeds the fixed 32-bit, 16-position shift unit in the project. It adds the following over that unit:

- configurable data width;
- variable shift amount;
- left/right direction;
- a per-cycle step size, so area can be traded against latency.

It sits beside the ALU as a shared shift resource: one operation is accepted at a time and the result is held until the next one completes.

## Interface

Parameters:

- WIDTH, 32, data width in bits; must be ≥ 2.
- STEP, 4, maximum bit positions shifted per clock; 1 ≤ STEP ≤ WIDTH.
- AMT_W, $clog2(WIDTH), width of the shift-amount port.

Ports:

- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- start, input, 1, request pulse; sampled only in IDLE.
- dir, input, 1, direction: 0 = left, 1 = right.
- sra, input, 1, arithmetic right shift (sign fill); meaningful only for dir=1 with rotate=0.
- rotate, input, 1, rotate instead of shift; takes precedence over sra.
- a, input, WIDTH, operand.
- amt, input, AMT_W, shift amount, 0..WIDTH-1.
- busy, output, 1, high whenever the FSM is not in IDLE.
- done, output, 1, one-cycle pulse when result is valid.
- result, output, WIDTH, last completed result; holds its value between operations.

## Operation

- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - latch a into accumulator acc;
  - latch amt into remaining counter rem;
  - latch dir, sra and rotate;
  - if amt==0, go to DONE; otherwise go to SHIFT.
- IDLE, start=0: stay in IDLE.
- SHIFT, each cycle:
  - k = min(STEP, rem);
  - acc ← acc shifted by k in the latched mode;
  - rem ← rem − k;
  - if rem − k == 0, go to DONE and load result ← the new acc in the same edge.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- For amt==0, result ← a on the edge that enters DONE.
- Mode decode (latched values):
  - rotate=1, dir=0: rotate left; bits leaving the MSB enter the LSB.
  - rotate=1, dir=1: rotate right; sra is ignored.
  - rotate=0, dir=0: logical left, zero fill; sra is ignored.
  - rotate=0, dir=1, sra=0: logical right, zero fill.
  - rotate=0, dir=1, sra=1: arithmetic right; fill with the original a[WIDTH-1]. The sign is preserved across all steps.
- Inputs a, amt, dir, sra and rotate may change freely after the start cycle; only the latched copies are used.
- start asserted in SHIFT or DONE is ignored. It is not queued.
- Back-to-back operation: start may be reasserted in the first IDLE cycle after done.
- Width rule: rem is AMT_W bits wide and k never exceeds rem, so there is no underflow or wrap.
- Reset (rst=1 at any edge, including mid-operation):
  - state ← IDLE, acc ← 0, rem ← 0, result ← 0;
  - busy=0, done=0 in the following cycle;
  - any in-flight operation is abandoned and produces no done;
  - rst has priority over start.

## Timing

- Let n = ceil(amt/STEP).
- start sampled at edge E0.
- busy is high from the cycle after E0 until done deasserts.
- done and the new result are visible n+1 cycles after the start cycle.
  - amt=0: 1 cycle.
  - WIDTH=32, STEP=4, amt=31: 9 cycles.
- Minimum issue interval is n+2 cycles, because of the IDLE cycle after DONE.
- result changes only on the edge entering DONE, or on reset.

## Test plan

Default parameters (WIDTH=32, STEP=4) unless noted.

- Logical left: a=12345678, amt=16, dir=0 → result=56780000; done 5 cycles after start; busy high for those 5 cycles.
- Arithmetic right: a=87654321, amt=16, dir=1, sra=1 → FFFF8765. Repeat with sra=0 → 00008765.
- Rotates:
  - a=FEDCBA98, amt=8, dir=1, rotate=1, sra=1 → 98FEDCBA (sra ignored);
  - a=C0FFEE01, amt=4, dir=0, rotate=1 → 0FFEE01C.
- Boundaries:
  - amt=0, a=ABCDEFFF → ABCDEFFF with done 1 cycle after start;
  - a=80000000, amt=31, right logical → 00000001 after 9 cycles;
  - the same operand with sra=1 → FFFFFFFF.
- Handshake and reset:
  - start pulsed again mid-SHIFT → ignored; the first result is unchanged and only one done pulse occurs;
  - rst asserted mid-SHIFT → busy=0, done=0, result=00000000 next cycle, and no done follows.
- Parameter sweep: for WIDTH=16 with STEP ∈ {1, 3, 16}, run random operands against a behavioural model. Check results and latency n+1 for every amt in 0..15.

Source files
------------

// File: rtl/seq_shifter.sv
// Iterative shifter/rotator: one operation at a time, up to STEP bit positions per clock.
// The result register holds the last completed value until the next operation finishes.
module seq_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             dir,
    input  logic             sra,
    input  logic             rotate,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // A step larger than WIDTH-1 can never be taken in full, because rem < WIDTH.
    localparam int               STEP_SAT = (STEP > WIDTH - 1) ? WIDTH - 1 : STEP;
    localparam logic [AMT_W-1:0] STEP_K   = AMT_W'(STEP_SAT);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_n;
    logic [AMT_W-1:0]   rem;
    logic [AMT_W-1:0]   k;
    logic               dir_q;
    logic               sra_q;
    logic               rot_q;
    logic               sign_q;
    logic [2*WIDTH-1:0] dbl;
    logic [2*WIDTH-1:0] dbl_l;
    logic [2*WIDTH-1:0] dbl_r;
    logic [WIDTH-1:0]   fill;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        busy    = (state != IDLE);
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = (amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (rem == k) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Rotates use a doubled copy of acc so the wrapped bits fall out of a plain shift.
    always_comb begin
        k     = (rem < STEP_K) ? rem : STEP_K;
        dbl   = {acc, acc};
        dbl_l = dbl << k;
        dbl_r = dbl >> k;
        fill  = ~({WIDTH{1'b1}} >> k);
        acc_n = acc;
        if (rot_q) begin
            acc_n = dir_q ? dbl_r[WIDTH-1:0] : dbl_l[2*WIDTH-1:WIDTH];
        end else if (!dir_q) begin
            acc_n = acc << k;
        end else if (sra_q && sign_q) begin
            acc_n = (acc >> k) | fill;
        end else begin
            acc_n = acc >> k;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            rem    <= '0;
            result <= '0;
            dir_q  <= 1'b0;
            sra_q  <= 1'b0;
            rot_q  <= 1'b0;
            sign_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc    <= a;
                        rem    <= amt;
                        dir_q  <= dir;
                        sra_q  <= sra;
                        rot_q  <= rotate;
                        sign_q <= a[WIDTH-1];
                        if (amt == '0) begin
                            result <= a;
                        end
                    end
                end
                SHIFT: begin
                    acc <= acc_n;
                    rem <= rem - k;
                    if (rem == k) begin
                        result <= acc_n;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Randomised self-checking bench for seq_shifter: a 32-bit/STEP=4 instance plus
// three 16-bit instances (STEP 1, 3, 16) compared against a plain-arithmetic model.
module tb_seq_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        dir;
    logic        sra;
    logic        rotate;
    logic [31:0] a;
    logic [4:0]  amt;
    logic        busy;
    logic        done;
    logic [31:0] result;

    logic        s_start [3];
    logic        s_dir   [3];
    logic        s_sra   [3];
    logic        s_rot   [3];
    logic [15:0] s_a     [3];
    logic [3:0]  s_amt   [3];
    logic        s_busy  [3];
    logic        s_done  [3];
    logic [15:0] s_res   [3];

    int steps16 [3] = '{1, 3, 16};
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_shifter #(.WIDTH(32), .STEP(4)) dut (
        .clk(clk), .rst(rst), .start(start), .dir(dir), .sra(sra), .rotate(rotate),
        .a(a), .amt(amt), .busy(busy), .done(done), .result(result)
    );

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g16
            localparam int S = (g == 0) ? 1 : ((g == 1) ? 3 : 16);
            seq_shifter #(.WIDTH(16), .STEP(S)) u (
                .clk(clk), .rst(rst), .start(s_start[g]), .dir(s_dir[g]), .sra(s_sra[g]),
                .rotate(s_rot[g]), .a(s_a[g]), .amt(s_amt[g]), .busy(s_busy[g]),
                .done(s_done[g]), .result(s_res[g])
            );
        end
    endgenerate

    // Whole-amount reference: the final value of an operation in one expression.
    function automatic logic [31:0] ref_shift(input int w, input logic [31:0] av, input int sh,
                                              input bit d, input bit s, input bit r);
        logic [31:0] mask;
        logic [31:0] v;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        v = av & mask;
        if (sh == 0) return v;
        if (r) begin
            if (!d) return ((v << sh) | (v >> (w - sh))) & mask;
            return ((v >> sh) | (v << (w - sh))) & mask;
        end
        if (!d) return (v << sh) & mask;
        if (s && v[w-1]) return (v >> sh) | (mask & ~(mask >> sh));
        return v >> sh;
    endfunction

    task automatic op32(input logic [31:0] av, input int sh, input bit d, input bit s, input bit r,
                        output logic [31:0] res, output int lat, output bit busy_ok, output bit idle_ok);
        a = av; amt = sh[4:0]; dir = d; sra = s; rotate = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; amt = 5'($urandom);
        dir = 1'($urandom); sra = 1'($urandom); rotate = 1'($urandom);
        lat = 1;
        busy_ok = busy;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (!busy) busy_ok = 1'b0;
        end
        res = result;
        @(posedge clk); #1;
        idle_ok = !done && !busy;
    endtask

    task automatic op16(input int idx, input logic [15:0] av, input int sh, input bit d, input bit s,
                        input bit r, output logic [15:0] res, output int lat);
        s_a[idx] = av; s_amt[idx] = sh[3:0]; s_dir[idx] = d; s_sra[idx] = s; s_rot[idx] = r;
        s_start[idx] = 1'b1;
        @(posedge clk); #1;
        s_start[idx] = 1'b0; s_a[idx] = 16'($urandom); s_amt[idx] = 4'($urandom);
        lat = 1;
        while (!s_done[idx] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = s_res[idx];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_result: got %h expected 00000000", result); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] res;
        int lat;
        bit bok, iok;
        op32(32'h12345678, 16, 0, 0, 0, res, lat, bok, iok);
        n_checks++; if (res !== 32'h56780000) begin n_fail++; $display("[TB] FAIL lsl16_result: got %h expected 56780000", res); end
        n_checks++; if (lat != 5) begin n_fail++; $display("[TB] FAIL lsl16_latency: got %0d expected 5", lat); end
        n_checks++; if (!bok) begin n_fail++; $display("[TB] FAIL lsl16_busy: busy dropped before done"); end
        n_checks++; if (!iok) begin n_fail++; $display("[TB] FAIL lsl16_done_pulse: done/busy still high after done cycle"); end
        op32(32'h87654321, 16, 1, 1, 0, res, lat, bok, iok);
        n_checks++; if (res !== 32'hFFFF8765) begin n_fail++; $display("[TB] FAIL asr16_result: got %h expected FFFF8765", res); end
        op32(32'h87654321, 16, 1, 0, 0, res, lat, bok, iok);
        n_checks++; if (res !== 32'h00008765) begin n_fail++; $display("[TB] FAIL lsr16_result: got %h expected 00008765", res); end
        op32(32'hFEDCBA98, 8, 1, 1, 1, res, lat, bok, iok);
        n_checks++; if (res !== 32'h98FEDCBA) begin n_fail++; $display("[TB] FAIL ror8_result: got %h expected 98FEDCBA", res); end
        op32(32'hC0FFEE01, 4, 0, 0, 1, res, lat, bok, iok);
        n_checks++; if (res !== 32'h0FFEE01C) begin n_fail++; $display("[TB] FAIL rol4_result: got %h expected 0FFEE01C", res); end
    endtask

    task automatic test_boundaries();
        logic [31:0] res;
        int lat;
        bit bok, iok;
        op32(32'hABCDEFFF, 0, 0, 0, 0, res, lat, bok, iok);
        n_checks++; if (res !== 32'hABCDEFFF) begin n_fail++; $display("[TB] FAIL amt0_result: got %h expected ABCDEFFF", res); end
        n_checks++; if (lat != 1) begin n_fail++; $display("[TB] FAIL amt0_latency: got %0d expected 1", lat); end
        op32(32'h80000000, 31, 1, 0, 0, res, lat, bok, iok);
        n_checks++; if (res !== 32'h00000001) begin n_fail++; $display("[TB] FAIL lsr31_result: got %h expected 00000001", res); end
        n_checks++; if (lat != 9) begin n_fail++; $display("[TB] FAIL lsr31_latency: got %0d expected 9", lat); end
        op32(32'h80000000, 31, 1, 1, 0, res, lat, bok, iok);
        n_checks++; if (res !== 32'hFFFFFFFF) begin n_fail++; $display("[TB] FAIL asr31_result: got %h expected FFFFFFFF", res); end
    endtask

    task automatic test_start_ignored();
        int ndone = 0;
        logic [31:0] res_at = 32'h0;
        a = 32'h80000000; amt = 5'd31; dir = 1'b1; sra = 1'b0; rotate = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (done) begin ndone++; res_at = result; end
            if (c == 3) begin
                a = 32'hFFFFFFFF; amt = 5'd1; dir = 1'b0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        n_checks++; if (ndone != 1) begin n_fail++; $display("[TB] FAIL restart_done_count: got %0d expected 1", ndone); end
        n_checks++; if (res_at !== 32'h00000001) begin n_fail++; $display("[TB] FAIL restart_result: got %h expected 00000001", res_at); end
        n_checks++; if (result !== 32'h00000001) begin n_fail++; $display("[TB] FAIL restart_hold: got %h expected 00000001", result); end
    endtask

    task automatic test_reset_mid();
        int ndone = 0;
        a = 32'h12345678; amt = 5'd31; dir = 1'b0; sra = 1'b0; rotate = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_done: got %b expected 0", done); end
        n_checks++; if (result !== 32'h0) begin n_fail++; $display("[TB] FAIL midrst_result: got %h expected 00000000", result); end
        rst = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        n_checks++; if (ndone != 0) begin n_fail++; $display("[TB] FAIL midrst_no_done: got %0d done pulses expected 0", ndone); end
    endtask

    task automatic test_random32();
        logic [31:0] av, res, exp_v;
        int sh, lat;
        bit d, s, r, bok, iok;
        for (int i = 0; i < 24; i++) begin
            av = $urandom; sh = $urandom_range(0, 31);
            d = 1'($urandom); s = 1'($urandom); r = 1'($urandom);
            exp_v = ref_shift(32, av, sh, d, s, r);
            op32(av, sh, d, s, r, res, lat, bok, iok);
            n_checks++;
            if (res !== exp_v) begin
                n_fail++;
                $display("[TB] FAIL rand32_result a=%h amt=%0d dir=%b sra=%b rot=%b: got %h expected %h", av, sh, d, s, r, res, exp_v);
            end
            n_checks++;
            if (lat != (sh + 3) / 4 + 1) begin
                n_fail++;
                $display("[TB] FAIL rand32_latency amt=%0d: got %0d expected %0d", sh, lat, (sh + 3) / 4 + 1);
            end
        end
    endtask

    task automatic test_sweep16();
        logic [15:0] av, res, exp_v;
        int lat, exp_lat;
        bit d, s, r;
        for (int idx = 0; idx < 3; idx++) begin
            for (int sh = 0; sh < 16; sh++) begin
                av = 16'($urandom);
                d = 1'($urandom); s = 1'($urandom); r = 1'($urandom);
                exp_v = 16'(ref_shift(16, 32'(av), sh, d, s, r));
                exp_lat = (sh + steps16[idx] - 1) / steps16[idx] + 1;
                op16(idx, av, sh, d, s, r, res, lat);
                n_checks++;
                if (res !== exp_v) begin
                    n_fail++;
                    $display("[TB] FAIL sweep16_result step=%0d a=%h amt=%0d dir=%b sra=%b rot=%b: got %h expected %h",
                             steps16[idx], av, sh, d, s, r, res, exp_v);
                end
                n_checks++;
                if (lat != exp_lat) begin
                    n_fail++;
                    $display("[TB] FAIL sweep16_latency step=%0d amt=%0d: got %0d expected %0d", steps16[idx], sh, lat, exp_lat);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dir = 1'b0; sra = 1'b0; rotate = 1'b0; a = '0; amt = '0;
        for (int i = 0; i < 3; i++) begin
            s_start[i] = 1'b0; s_dir[i] = 1'b0; s_sra[i] = 1'b0; s_rot[i] = 1'b0;
            s_a[i] = '0; s_amt[i] = '0;
        end
        test_reset();
        test_directed();
        test_boundaries();
        test_start_ignored();
        test_reset_mid();
        test_random32();
        test_sweep16();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
